// File: rtl/tagged_reg_file.sv
// tagged_reg_file: architectural register file with per-register busy/tag
// scoreboard for an out-of-order core.
//   clk, reset        : clock (rising edge), asynchronous active-high reset
//   rd_addr           : NRD packed read addresses, port i at [i*AW +: AW]
//   rd_data/busy/tag  : combinational read results per port (with commit bypass)
//   issue_*           : allocate destination register to a producer ROB tag
//   commit_*          : retire a result; clears busy only on a tag match
//   flush             : clear every busy bit (values and tags kept)
//   busy_cnt          : registered count of busy registers

// Per-read-port lane: x0 masking and same-cycle commit bypass.
//   reg_value/busy/tag : state of the addressed register
//   commit_*           : current-cycle commit, forwarded on a tag match
module tagged_reg_file_rd_lane #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int AW    = 5
) (
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  reg_value,
  input  logic             reg_busy,
  input  logic [TAG_W-1:0] reg_tag,
  input  logic             commit_valid,
  input  logic [AW-1:0]    commit_rd,
  input  logic [TAG_W-1:0] commit_tag,
  input  logic [XLEN-1:0]  commit_data,
  output logic [XLEN-1:0]  rd_data,
  output logic             rd_busy,
  output logic [TAG_W-1:0] rd_tag
);
  logic bypass;

  // Only the producer the register is waiting on may forward its value.
  assign bypass = commit_valid && (commit_rd == addr) && reg_busy &&
                  (reg_tag == commit_tag);

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    rd_tag  = '0;
    if (addr != '0) begin
      rd_data = bypass ? commit_data : reg_value;
      rd_busy = reg_busy && !bypass;
      rd_tag  = reg_tag;
    end
  end
endmodule

module tagged_reg_file #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAG_W-1:0] rd_tag,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rd,
  input  logic [TAG_W-1:0]     issue_tag,
  input  logic                 commit_valid,
  input  logic [AW-1:0]        commit_rd,
  input  logic [TAG_W-1:0]     commit_tag,
  input  logic [XLEN-1:0]      commit_data,
  input  logic                 flush,
  output logic [AW:0]          busy_cnt
);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]  value_q [NREG];
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [NREG-1:0]  busy_q;

  logic [NREG-1:0]  busy_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             issue_en;
  logic             commit_en;

  // x0 is never a target; flush suppresses a same-cycle issue.
  assign issue_en  = issue_valid && (issue_rd != '0) && !flush;
  assign commit_en = commit_valid && (commit_rd != '0);

  // Next busy vector: commit clears on tag match, flush clears all,
  // issue sets last so it wins over a same-register commit.
  always_comb begin
    busy_nxt = busy_q;
    if (commit_en && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag))
      busy_nxt[commit_rd] = 1'b0;
    if (flush)
      busy_nxt = '0;
    if (issue_en)
      busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Count is the popcount of the post-edge busy vector, so every
  // issue/commit/flush interaction is covered by construction.
  always_comb begin
    cnt_nxt = '0;
    for (int r = 1; r < NREG; r++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= '0;
      busy_cnt <= '0;
      for (int r = 0; r < NREG; r++) begin
        value_q[r] <= '0;
        tag_q[r]   <= '0;
      end
    end else begin
      busy_q   <= busy_nxt;
      busy_cnt <= cnt_nxt;
      if (commit_en)
        value_q[commit_rd] <= commit_data;
      if (issue_en)
        tag_q[issue_rd] <= issue_tag;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    assign a = rd_addr[i*AW +: AW];

    tagged_reg_file_rd_lane #(
      .XLEN (XLEN),
      .TAG_W(TAG_W),
      .AW   (AW)
    ) u_lane (
      .addr        (a),
      .reg_value   (value_q[a]),
      .reg_busy    (busy_q[a]),
      .reg_tag     (tag_q[a]),
      .commit_valid(commit_valid),
      .commit_rd   (commit_rd),
      .commit_tag  (commit_tag),
      .commit_data (commit_data),
      .rd_data     (rd_data[i*XLEN +: XLEN]),
      .rd_busy     (rd_busy[i]),
      .rd_tag      (rd_tag[i*TAG_W +: TAG_W])
    );
  end
endmodule

// File: tb/tb_tagged_reg_file.sv
module tb_tagged_reg_file;
  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int TAG_W = 4;
  localparam int NRD   = 2;
  localparam int AW    = $clog2(NREG);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TAG_W-1:0] rd_tag;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic [TAG_W-1:0]     issue_tag;
  logic                 commit_valid;
  logic [AW-1:0]        commit_rd;
  logic [TAG_W-1:0]     commit_tag;
  logic [XLEN-1:0]      commit_data;
  logic                 flush;
  logic [AW:0]          busy_cnt;

  int total = 0;
  int bad   = 0;

  // Reference state: plain arrays, updated by the architectural rules.
  logic [XLEN-1:0]  mval  [NREG];
  logic             mbusy [NREG];
  logic [TAG_W-1:0] mtag  [NREG];

  always #5 clk = ~clk;

  tagged_reg_file #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_tag(rd_tag), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_tag(issue_tag), .commit_valid(commit_valid),
    .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_data(commit_data),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      mval[r] = '0; mbusy[r] = 1'b0; mtag[r] = '0;
    end
  endtask

  function automatic int model_cnt();
    int n = 0;
    for (int r = 0; r < NREG; r++) n += int'(mbusy[r]);
    return n;
  endfunction

  task automatic idle();
    issue_valid = 0; issue_rd = '0; issue_tag = '0;
    commit_valid = 0; commit_rd = '0; commit_tag = '0; commit_data = '0;
    flush = 0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic issue(input int r, input int t);
    issue_valid = 1; issue_rd = AW'(r); issue_tag = TAG_W'(t);
  endtask

  task automatic commit(input int r, input int t, input logic [XLEN-1:0] d);
    commit_valid = 1; commit_rd = AW'(r); commit_tag = TAG_W'(t); commit_data = d;
  endtask

  // Expected read of one port from reference state and current commit inputs.
  task automatic check_reads();
    for (int i = 0; i < NRD; i++) begin
      int a;
      logic byp;
      logic [XLEN-1:0] ed;
      logic eb;
      logic [TAG_W-1:0] et;
      a = int'(rd_addr[i*AW +: AW]);
      ed = '0; eb = 0; et = '0;
      if (a != 0) begin
        byp = commit_valid && int'(commit_rd) == a && mbusy[a] && mtag[a] == commit_tag;
        ed = byp ? commit_data : mval[a];
        eb = mbusy[a] && !byp;
        et = mtag[a];
      end
      chk($sformatf("rd_data[%0d] x%0d", i, a), 64'(rd_data[i*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("rd_busy[%0d] x%0d", i, a), 64'(rd_busy[i]), 64'(eb));
      chk($sformatf("rd_tag[%0d] x%0d", i, a), 64'(rd_tag[i*TAG_W +: TAG_W]), 64'(et));
    end
  endtask

  task automatic model_edge();
    int cr, ir;
    cr = int'(commit_rd); ir = int'(issue_rd);
    if (commit_valid && cr != 0) begin
      if (mbusy[cr] && mtag[cr] == commit_tag) mbusy[cr] = 0;
      mval[cr] = commit_data;
    end
    if (flush) begin
      for (int r = 0; r < NREG; r++) mbusy[r] = 0;
    end else if (issue_valid && ir != 0) begin
      mbusy[ir] = 1; mtag[ir] = issue_tag;
    end
  endtask

  // Called just after a rising edge with inputs already driven; returns
  // just after the next rising edge.
  task automatic do_cycle();
    @(negedge clk);
    check_reads();
    @(posedge clk);
    model_edge();
    #1;
    chk("busy_cnt", 64'(busy_cnt), 64'(model_cnt()));
  endtask

  task automatic rand_inputs();
    int r;
    idle();
    set_rd($urandom_range(0, NREG-1), $urandom_range(0, NREG-1));
    if ($urandom_range(0, 3) != 0) issue($urandom_range(0, NREG-1), $urandom_range(0, 15));
    if ($urandom_range(0, 2) != 0) begin
      r = $urandom_range(0, NREG-1);
      commit(r, ($urandom_range(0, 1) == 1) ? int'(mtag[r]) : $urandom_range(0, 15), $urandom);
      if ($urandom_range(0, 1) == 1) set_rd(r, $urandom_range(0, NREG-1));
    end
    if ($urandom_range(0, 19) == 0) flush = 1;
  endtask

  initial begin
    reset = 1; idle(); set_rd(0, 0); model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 0;

    // Post-reset reads
    set_rd(5, 5); #1;
    chk("rst rd_data0", 64'(rd_data[31:0]), 64'h0);
    chk("rst rd_data1", 64'(rd_data[63:32]), 64'h0);
    chk("rst rd_busy", 64'(rd_busy), 64'h0);
    chk("rst rd_tag", 64'(rd_tag), 64'h0);
    chk("rst busy_cnt", 64'(busy_cnt), 64'h0);

    // Issue then commit with bypass
    issue(3, 7); do_cycle();
    idle(); set_rd(3, 3); #1;
    chk("x3 busy", 64'(rd_busy), 64'h3);
    chk("x3 tag", 64'(rd_tag[3:0]), 64'h7);
    chk("x3 cnt", 64'(busy_cnt), 64'h1);
    commit(3, 7, 32'hDEADBEEF); #1;
    chk("x3 bypass data", 64'(rd_data[31:0]), 64'hDEADBEEF);
    chk("x3 bypass busy", 64'(rd_busy), 64'h0);
    do_cycle();
    idle(); #1;
    chk("x3 held", 64'(rd_data[63:32]), 64'hDEADBEEF);
    chk("x3 cnt0", 64'(busy_cnt), 64'h0);

    // Stale-tag commit does not clear a re-issued register
    issue(4, 2); do_cycle();
    issue(4, 9); do_cycle();
    idle(); commit(4, 2, 32'h11); set_rd(4, 4); do_cycle();
    idle(); #1;
    chk("x4 value", 64'(rd_data[31:0]), 64'h11);
    chk("x4 busy", 64'(rd_busy[0]), 64'h1);
    chk("x4 tag", 64'(rd_tag[3:0]), 64'h9);
    chk("x4 cnt", 64'(busy_cnt), 64'h1);

    // Same-cycle commit + issue to the same register
    issue(6, 1); do_cycle();
    idle(); commit(6, 1, 32'h55); issue(6, 3); set_rd(6, 4); do_cycle();
    idle(); #1;
    chk("x6 value", 64'(rd_data[31:0]), 64'h55);
    chk("x6 busy", 64'(rd_busy[0]), 64'h1);
    chk("x6 tag", 64'(rd_tag[3:0]), 64'h3);
    chk("x6 cnt", 64'(busy_cnt), 64'h2);

    // Flush with simultaneous issue and commit
    issue(1, 4); do_cycle();
    issue(2, 5); do_cycle();
    issue(3, 6); do_cycle();
    idle(); flush = 1; issue(8, 10); commit(2, 0, 32'hAA); set_rd(2, 8); do_cycle();
    idle(); #1;
    chk("flush x2 value", 64'(rd_data[31:0]), 64'hAA);
    chk("flush busy", 64'(rd_busy), 64'h0);
    chk("flush cnt", 64'(busy_cnt), 64'h0);
    set_rd(3, 6); #1;
    chk("flush x3/x6 busy", 64'(rd_busy), 64'h0);

    // x0 writes are ignored
    issue(5, 1); do_cycle();
    idle(); issue(0, 5); commit(0, 0, 32'hFFFF); set_rd(0, 5); do_cycle();
    idle(); #1;
    chk("x0 data", 64'(rd_data[31:0]), 64'h0);
    chk("x0 busy", 64'(rd_busy[0]), 64'h0);
    chk("x0 tag", 64'(rd_tag[3:0]), 64'h0);
    chk("x0 cnt", 64'(busy_cnt), 64'h1);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      rand_inputs(); do_cycle();
    end
    for (int n = 1; n < 6; n++) begin
      idle(); issue(n, n); do_cycle();
    end

    // Asynchronous reset mid-sequence, checked between clock edges
    idle(); issue(7, 3); commit(1, 1, 32'h1234);
    #2 reset = 1;
    #1;
    chk("arst cnt", 64'(busy_cnt), 64'h0);
    model_reset();
    for (int a = 0; a < NREG; a += 3) begin
      set_rd(a, NREG-1-a); #1;
      chk($sformatf("arst data x%0d", a), 64'(rd_data), 64'h0);
      chk($sformatf("arst busy x%0d", a), 64'(rd_busy), 64'h0);
      chk($sformatf("arst tag x%0d", a), 64'(rd_tag), 64'h0);
    end
    @(posedge clk); #1;
    chk("arst held cnt", 64'(busy_cnt), 64'h0);
    reset = 0;

    // First edges after reset behave normally
    idle(); issue(9, 12); set_rd(9, 1); do_cycle();
    for (int n = 0; n < 100; n++) begin
      rand_inputs(); do_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tagged_reg_file.md
TAGGED_REG_FILE -- requirements
Module: tagged_reg_file

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- XLEN, 32, data width.
- NREG, 32, register count (power of 2, >=2).
- TAG_W, 4, ROB tag width.
- NRD, 2, read-port count (>=1).
- AW = $clog2(NREG), derived, address width.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-high reset.
- rd_addr, in, NRD*AW, packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data, out, NRD*XLEN, read values.
- rd_busy, out, NRD, 1 = value pending from ROB.
- rd_tag, out, NRD*TAG_W, pending producer tag.
- issue_valid, in, 1, allocate destination.
- issue_rd, in, AW, destination register.
- issue_tag, in, TAG_W, producer ROB tag.
- commit_valid, in, 1, retire result.
- commit_rd, in, AW, retiring destination.
- commit_tag, in, TAG_W, retiring ROB tag.
- commit_data, in, XLEN, retiring value.
- flush, in, 1, mispredict recovery.
- busy_cnt, out, AW+1, registered number of busy registers.

Function
REQ-003 State per register: value[XLEN], busy bit, tag[TAG_W]. Register 0 reads 0, is never busy and returns tag 0; any write, issue or commit addressed to it has no effect.
REQ-004 Issue: on a clock edge with issue_valid and issue_rd!=0, set busy[issue_rd]=1 and tag[issue_rd]=issue_tag.
REQ-005 Commit: on a clock edge with commit_valid and commit_rd!=0, write value[commit_rd]=commit_data unconditionally.
- Clear busy[commit_rd] only if busy=1 and tag[commit_rd]==commit_tag.
REQ-006 Issue and commit to the same register in the same cycle: value is written from commit; busy=1 and tag=issue_tag (issue wins).
REQ-007 Flush: on a clock edge with flush=1, clear all busy bits; values and tags are retained. A simultaneous issue is ignored. A simultaneous commit still writes its value.
REQ-008 Reads are combinational, per port i, from state before the current edge.
REQ-009 Commit bypass: if commit_valid, commit_rd==rd_addr[i]!=0, busy=1 and tag==commit_tag, then rd_data[i]=commit_data and rd_busy[i]=0.
REQ-010 An issue in the current cycle is not visible on read ports until the next cycle.
REQ-011 busy_cnt equals the population count of the busy bits after each edge.
- Update per edge: +1 on issue to a non-busy register; -1 on a tag-matching commit; net 0 when both hit the same register.
- Set to 0 on flush.
- Never exceeds NREG-1.
REQ-012 All read ports are independent. Identical addresses on several ports return identical results.

Reset
REQ-013 Asserting reset asynchronously clears all values, busy bits, tags and busy_cnt to 0.
- rd_data, rd_busy and rd_tag therefore read 0 for every address while reset is held.
REQ-014 Reset dominates issue, commit and flush. Reset asserted mid-operation discards all pending state.
REQ-015 The first edge after reset deassertion processes inputs normally.

Verification
REQ-016 Reset, then read x5 on both ports -> rd_data=0, rd_busy=0, rd_tag=0, busy_cnt=0.
REQ-017 Issue x3 with tag 7, then next cycle read x3 -> busy=1, tag=7, busy_cnt=1.
- Then commit x3 with tag 7, data 0xDEADBEEF; same-cycle read -> rd_data=0xDEADBEEF, busy=0 (bypass).
- Following cycle -> value held, busy_cnt=0.
REQ-018 Issue x4 with tag 2, then re-issue x4 with tag 9, then commit x4 with tag 2, data 0x11.
- Result -> value 0x11, busy=1, tag=9, busy_cnt=1.
REQ-019 Same-cycle commit x6 (tag 1, data 0x55) and issue x6 (tag 3), with x6 previously busy with tag 1.
- Result -> value 0x55, busy=1, tag=3, busy_cnt unchanged.
REQ-020 Busy x1, x2 and x3, then flush together with issue x8 and commit x2 (data 0xAA).
- Result -> all busy=0, x8 not busy, value[x2]=0xAA, busy_cnt=0.
REQ-021 Issue/commit to x0 with data 0xFFFF -> x0 reads 0, not busy, busy_cnt unchanged.
- Then assert reset mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.
